// File: rtl/core_pkg.sv
// Shared definitions for the write-back path: register-file geometry,
// the write-back request record, and the fixed requester indices.
package core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REG    = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    localparam int WB_SRC_EX  = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_CSR = 2;

endpackage

// File: rtl/core_rr_arbiter.sv
// Round-robin arbiter with internal priority pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req [N]    : request vector
//   en         : 0 forces gnt to zero and freezes the pointer
//   gnt [N]    : one-hot (or zero) grant, combinational
// The scan starts at the pointer and wraps; after a grant to i the pointer
// moves to i+1 so the winner gets lowest priority next time.
module core_rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          found;

    always_comb begin
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = (int'(ptr) + off) % N;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                ptr_next = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/core_wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port among
// NUM_REQ sources (0 = EX, 1 = LSU, 2 = CSR) and keeps the busy scoreboard.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : per-source handshake, ready is combinational one-hot
//   req_addr/req_data : per-source destination register and data (flat slices)
//   wb_hold           : suppresses all grants (debug halt / flush)
//   alloc_en/addr     : ID marks a destination register busy on issue
//   rf_write_*        : registered register-file write port
//   busy              : scoreboard, bit 0 always 0
//   grant_id          : index of the last granted source (registered)
import core_pkg::*;

module core_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*5-1:0]    req_addr,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    input  logic                    wb_hold,
    input  logic                    alloc_en,
    input  logic [4:0]              alloc_addr,
    output logic                    rf_write_en,
    output logic [4:0]              rf_write_addr,
    output logic [XLEN-1:0]         rf_write_data,
    output logic [31:0]             busy,
    output logic [2:0]              grant_id
);

    logic [NUM_REQ-1:0]    gnt;
    logic                  arb_en;
    logic                  xfer;
    logic [2:0]            sel_idx;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;
    logic [NUM_REG-1:0]    busy_next;

    // Gating with rst_n keeps ready low for the whole time reset is held,
    // not just until the first clock edge.
    assign arb_en = rst_n && !wb_hold;

    core_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (arb_en),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_idx  = 3'(i);
                sel_addr = req_addr[5*i +: 5];
                sel_data = req_data[XLEN*i +: XLEN];
            end
        end
    end

    // A write to x0 still completes the handshake but never strobes the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            grant_id      <= '0;
        end else begin
            rf_write_en <= xfer && (sel_addr != '0);
            if (xfer) begin
                rf_write_addr <= sel_addr;
                rf_write_data <= sel_data;
                grant_id      <= sel_idx;
            end
        end
    end

    // Clear applied before set so a same-register collision leaves the bit set.
    always_comb begin
        busy_next = busy;
        if (rf_write_en) begin
            busy_next[rf_write_addr] = 1'b0;
        end
        if (alloc_en && (alloc_addr != '0)) begin
            busy_next[alloc_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_core_wb_arbiter.sv
module tb_core_wb_arbiter;

    localparam int N = 3;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*5-1:0]  req_addr;
    logic [N*32-1:0] req_data;
    logic          wb_hold;
    logic          alloc_en;
    logic [4:0]    alloc_addr;
    logic          rf_write_en;
    logic [4:0]    rf_write_addr;
    logic [31:0]   rf_write_data;
    logic [31:0]   busy;
    logic [2:0]    grant_id;

    logic [4:0]  a [N];
    logic [31:0] d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[5*i +: 5]   = a[i];
            req_data[32*i +: 32] = d[i];
        end
    end

    core_wb_arbiter #(.NUM_REQ(N), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .wb_hold       (wb_hold),
        .alloc_en      (alloc_en),
        .alloc_addr    (alloc_addr),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Reference model: pending write record, pointer, and busy set.
    int          m_ptr;
    bit          m_en;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    bit [2:0]    m_gid;
    bit [31:0]   m_busy;
    int          last_gnt;

    task automatic model_reset();
        m_ptr = 0; m_en = 0; m_addr = 0; m_data = 0; m_gid = 0; m_busy = 0;
    endtask

    // One cycle: called at negedge with inputs already applied.
    task automatic step();
        int g;
        bit [2:0]  er;
        bit [31:0] nb;
        #1;
        g = -1;
        if (!wb_hold)
            for (int off = 0; off < N; off++) begin
                int i;
                i = (m_ptr + off) % N;
                if (g < 0 && req_valid[i]) g = i;
            end
        er = (g >= 0) ? 3'(1 << g) : 3'b000;
        chk("ready", req_ready, er);
        chk("wr_en", rf_write_en, m_en);
        chk("wr_addr", rf_write_addr, m_addr);
        chk("wr_data", rf_write_data, m_data);
        chk("busy", busy, m_busy);
        chk("gid", grant_id, m_gid);
        nb = m_busy;
        if (m_en) nb[m_addr] = 1'b0;
        if (alloc_en && alloc_addr != 0) nb[alloc_addr] = 1'b1;
        m_busy = nb;
        if (g >= 0) begin
            m_en = (a[g] != 0); m_addr = a[g]; m_data = d[g];
            m_gid = 3'(g); m_ptr = (g + 1) % N;
        end else begin
            m_en = 0;
        end
        last_gnt = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = '0; wb_hold = 0; alloc_en = 0; alloc_addr = 0;
        for (int i = 0; i < N; i++) begin a[i] = 0; d[i] = 0; end
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        model_reset();
    endtask

    int rr_exp_g [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        idle_inputs();
        rst_n = 1;
        model_reset();
        @(negedge clk);

        // Reset with everyone requesting.
        req_valid = 3'b111;
        rst_n = 0;
        #1;
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_wr_en", rf_write_en, 1'b0);
        chk("rst_busy", busy, 32'h0);
        @(posedge clk); #1;
        chk("rst_ready_edge", req_ready, 3'b000);
        do_reset();

        // Single write to x5 after allocation.
        alloc_en = 1; alloc_addr = 5;
        step();
        alloc_en = 0;
        chk("t2_busy_set", busy[5], 1'b1);
        req_valid = 3'b001; a[0] = 5; d[0] = 32'hDEADBEEF;
        step();
        req_valid = 0;
        chk("t2_wr_en", rf_write_en, 1'b1);
        chk("t2_wr_addr", rf_write_addr, 5'd5);
        chk("t2_wr_data", rf_write_data, 32'hDEADBEEF);
        chk("t2_busy_hold", busy[5], 1'b1);
        step();
        chk("t2_busy_clr", busy[5], 1'b0);
        chk("t2_wr_en_drop", rf_write_en, 1'b0);

        // Round robin with all three valid continuously.
        do_reset();
        req_valid = 3'b111;
        a[0] = 1; a[1] = 2; a[2] = 3;
        d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_gnt", last_gnt, rr_exp_g[k]);
            chk("rr_addr", rf_write_addr, 5'(k % 3 + 1));
            chk("rr_en", rf_write_en, 1'b1);
        end
        req_valid = 0;
        step();

        // x0 write from requester 1.
        req_valid = 3'b010; a[1] = 0; d[1] = 32'h1234;
        step();
        req_valid = 0;
        chk("x0_gnt", last_gnt, 1);
        chk("x0_wr_en", rf_write_en, 1'b0);
        chk("x0_busy", busy, m_busy);

        // Same-edge alloc and clear on x7.
        alloc_en = 1; alloc_addr = 7;
        step();
        alloc_en = 0;
        req_valid = 3'b001; a[0] = 7; d[0] = 32'h77;
        step();
        req_valid = 0;
        alloc_en = 1; alloc_addr = 7;
        step();
        alloc_en = 0;
        chk("t5_busy7", busy[7], 1'b1);

        // Hold with pointer at 2, then release.
        do_reset();
        req_valid = 3'b010; a[1] = 9; d[1] = 32'h99;
        step();
        req_valid = 3'b111; a[0] = 4; a[1] = 6; a[2] = 8;
        wb_hold = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_none", last_gnt, -1);
        end
        wb_hold = 0;
        alloc_en = 1; alloc_addr = 12;
        step();
        alloc_en = 0;
        chk("hold_rel_gnt", last_gnt, 2);
        step();
        chk("burst_wr_en", rf_write_en, 1'b1);
        // Asynchronous reset mid-burst, away from any clock edge.
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("arst_wr_en", rf_write_en, 1'b0);
        chk("arst_busy", busy, 32'h0);
        chk("arst_ready", req_ready, 3'b000);
        do_reset();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            wb_hold    = ($urandom_range(0, 9) == 0);
            alloc_en   = ($urandom_range(0, 2) == 0);
            alloc_addr = 5'($urandom_range(0, 31));
            step();
            for (int i = 0; i < N; i++) begin
                if (last_gnt == i || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    d[i] = $urandom;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
